// File: rtl/i2si_pkg.sv
// Shared definitions for the I2S-input frame scheduler.
package i2si_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

    // Default FIFO pointer width (FIFO depth = 2**BUF_WIDTH)
    localparam int BUF_WIDTH_DEF = 3;

    // Width of the dropped-frame counter
    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/i2si_sat_cnt.sv
// Saturating up-counter: increments on inc_i and stops at all-ones.
module i2si_sat_cnt
    import i2si_pkg::*;
#(
    parameter int W = DROP_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: hold unless incrementing below the ceiling
    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (which would infer a latch).
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/i2si_fifo_sched.sv
// Frame scheduler: captures a stereo sample pair and writes it to the
// I2S-input FIFO as one atomic byte burst (left MSB first, then right MSB
// first), starting only when the FIFO has room for the whole frame.
module i2si_fifo_sched
    import i2si_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2si_ctrl_en,
    input  logic                  i2si_smp_vld,
    input  logic [DATA_W-1:0]     i2si_smp_left,
    input  logic [DATA_W-1:0]     i2si_smp_right,
    output logic [7:0]            i2si_fifo_inp_data,
    output logic                  i2si_fifo_inp_rts,
    input  logic                  i2si_fifo_inp_rtr,
    input  logic [BUF_WIDTH:0]    i2si_fifo_counter,
    output logic                  i2si_ovf,
    input  logic                  i2si_ovf_clr,
    output logic [DROP_CNT_W-1:0] i2si_drop_cnt,
    output logic                  i2si_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int FB    = 2 * NB;
    localparam int IDX_W = $clog2(FB);
    localparam int FR_W  = 2 * DATA_W;

    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FB - 1);
    localparam logic [BUF_WIDTH+1:0] DEPTH    = (BUF_WIDTH + 2)'(2 ** BUF_WIDTH);
    localparam logic [BUF_WIDTH+1:0] FB_BYTES = (BUF_WIDTH + 2)'(FB);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic              ovf_q, ovf_d;

    logic [BUF_WIDTH+1:0] free;
    logic                 fire;
    logic                 last_fire;
    logic                 drop;
    logic [7:0]           byte_sel;

    // Free FIFO slots; one extra bit keeps depth minus occupancy unsigned
    assign free = DEPTH - {1'b0, i2si_fifo_counter};

    assign fire      = (state_q == ST_XFER) && i2si_fifo_inp_rtr;
    assign last_fire = fire && (idx_q == IDX_LAST);

    // Byte select: index 0 is the top byte of the left channel
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < FB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                byte_sel = frame_q[8*(FB-1-i) +: 8];
            end
        end
    end

    // FSM next state, frame capture and drop detection
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        drop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i2si_smp_vld && i2si_ctrl_en) begin
                    frame_d = {i2si_smp_left, i2si_smp_right};
                    idx_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                drop = i2si_smp_vld;
                if (free >= FB_BYTES) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // A frame landing on the final handshake is taken back-to-back
                drop = i2si_smp_vld && !(last_fire && i2si_ctrl_en);
                if (last_fire) begin
                    idx_d = '0;
                    if (i2si_smp_vld && i2si_ctrl_en) begin
                        frame_d = {i2si_smp_left, i2si_smp_right};
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (fire) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sticky overflow: a new drop wins over a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i2si_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State, index, frame and overflow registers
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the frame holder is an ordinary register, so it is reset along with the control state; this also makes data read as 0 after reset.
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
        end
    end

    i2si_sat_cnt #(
        .W (DROP_CNT_W)
    ) u_drop_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (drop),
        .cnt_o  (i2si_drop_cnt)
    );

    // Outputs decode from registers only; rtr never reaches rts
    assign i2si_fifo_inp_rts  = (state_q == ST_XFER);
    assign i2si_fifo_inp_data = (state_q == ST_XFER) ? byte_sel : 8'h00;
    assign i2si_busy          = (state_q != ST_IDLE);
    assign i2si_ovf           = ovf_q;

endmodule
